// File: rtl/fwd_pingpong_buffer_pkg.sv
// rtl/fwd_pingpong_buffer_pkg.sv - shared slot-state type and default packet-store widths
package fwd_pingpong_buffer_pkg;

    localparam int PKT_ADDR_WIDTH = 10;
    localparam int PKT_DATA_WIDTH = 64;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/fwd_pingpong_ram.sv
// rtl/fwd_pingpong_ram.sv - two-slot simple dual-port RAM addressed as {slot, addr}, registered read
module fwd_pingpong_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never cleared; only the read register returns to zero on reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fwd_pingpong_buffer.sv
// rtl/fwd_pingpong_buffer.sv - two-slot ping-pong packet store feeding the forwarder
// Optional packet statistics outputs enabled by defining FWD_PINGPONG_STATS_EN.
module fwd_pingpong_buffer
    import fwd_pingpong_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = PKT_ADDR_WIDTH,
    parameter int DATA_WIDTH = PKT_DATA_WIDTH
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  wr_done,
    input  logic [ADDR_WIDTH-1:0] wr_len,
    output logic                  ready_for_writer,
    input  logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    input  logic                  forwarder_rd_en,
    output logic [DATA_WIDTH-1:0] forwarder_rd_data,
    input  logic                  forwarder_done,
    output logic                  ready_for_forwarder,
`ifdef FWD_PINGPONG_STATS_EN
    output logic [31:0]           pkts_accepted,
    output logic [31:0]           pkts_aborted,
`endif
    output logic [ADDR_WIDTH-1:0] len_to_forwarder
);

    slot_state_t           slot_state [2];
    logic [ADDR_WIDTH-1:0] slot_len   [2];
    logic                  wp;
    logic                  rp;
    logic                  wr_accept;
    logic                  rd_release;

    assign ready_for_writer    = (slot_state[wp] == SLOT_EMPTY);
    assign ready_for_forwarder = (slot_state[rp] == SLOT_FULL);
    assign len_to_forwarder    = slot_len[rp];

    assign wr_accept  = wr_done && ready_for_writer;
    assign rd_release = forwarder_done && ready_for_forwarder;

    // When both handshakes fire together wp != rp, so the two updates never touch the same slot.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            slot_state[0] <= SLOT_EMPTY;
            slot_state[1] <= SLOT_EMPTY;
            slot_len[0]   <= '0;
            slot_len[1]   <= '0;
            wp            <= 1'b0;
            rp            <= 1'b0;
        end else begin
            if (wr_accept && (wr_len != '0)) begin
                slot_state[wp] <= SLOT_FULL;
                slot_len[wp]   <= wr_len;
                wp             <= ~wp;
            end
            if (rd_release) begin
                slot_state[rp] <= SLOT_EMPTY;
                rp             <= ~rp;
            end
        end
    end

`ifdef FWD_PINGPONG_STATS_EN
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkts_accepted <= '0;
            pkts_aborted  <= '0;
        end else if (wr_accept) begin
            if (wr_len != '0) begin
                if (pkts_accepted != 32'hFFFF_FFFF) begin
                    pkts_accepted <= pkts_accepted + 32'd1;
                end
            end else if (pkts_aborted != 32'hFFFF_FFFF) begin
                pkts_aborted <= pkts_aborted + 32'd1;
            end
        end
    end
`endif

    fwd_pingpong_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .wr_en   (wr_en && ready_for_writer),
        .wr_addr ({wp, wr_addr}),
        .wr_data (wr_data),
        .rd_en   (forwarder_rd_en),
        .rd_addr ({rp, forwarder_rd_addr}),
        .rd_data (forwarder_rd_data)
    );

endmodule

// File: tb/tb_fwd_pingpong_buffer.sv
// tb/tb_fwd_pingpong_buffer.sv - directed vector table plus randomized model comparison for fwd_pingpong_buffer
module tb_fwd_pingpong_buffer;

    localparam int AW = 10;
    localparam int DW = 64;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          wr_done;
    logic [AW-1:0] wr_len;
    logic          ready_for_writer;
    logic [AW-1:0] forwarder_rd_addr;
    logic          forwarder_rd_en;
    logic [DW-1:0] forwarder_rd_data;
    logic          forwarder_done;
    logic          ready_for_forwarder;
    logic [AW-1:0] len_to_forwarder;

    int errors = 0;
    int checks = 0;

    always #5 axi_aclk = ~axi_aclk;

    fwd_pingpong_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .axi_aclk            (axi_aclk),
        .axi_aresetn         (axi_aresetn),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .wr_en               (wr_en),
        .wr_done             (wr_done),
        .wr_len              (wr_len),
        .ready_for_writer    (ready_for_writer),
        .forwarder_rd_addr   (forwarder_rd_addr),
        .forwarder_rd_en     (forwarder_rd_en),
        .forwarder_rd_data   (forwarder_rd_data),
        .forwarder_done      (forwarder_done),
        .ready_for_forwarder (ready_for_forwarder),
        .len_to_forwarder    (len_to_forwarder)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          wdn;
        logic [AW-1:0] wl;
        logic          re;
        logic [AW-1:0] ra;
        logic          fd;
        logic          e_rfw;
        logic          e_rff;
        logic [AW-1:0] e_len;
        logic          chk_rd;
        logic [DW-1:0] e_rd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic we, input int wa, input logic [DW-1:0] wd,
                                input logic wdn, input int wl, input logic re, input int ra,
                                input logic fd, input logic e_rfw, input logic e_rff,
                                input int e_len, input logic chk_rd, input logic [DW-1:0] e_rd);
        vec_t v;
        v.we = we; v.wa = AW'(wa); v.wd = wd; v.wdn = wdn; v.wl = AW'(wl);
        v.re = re; v.ra = AW'(ra); v.fd = fd; v.e_rfw = e_rfw; v.e_rff = e_rff;
        v.e_len = AW'(e_len); v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic wdn, input logic [AW-1:0] wl, input logic re,
                         input logic [AW-1:0] ra, input logic fd);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_done = wdn; wr_len = wl;
        forwarder_rd_en = re; forwarder_rd_addr = ra; forwarder_done = fd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic apply(input vec_t v);
        drive(v.we, v.wa, v.wd, v.wdn, v.wl, v.re, v.ra, v.fd);
    endtask

    // Reference model: the two slots behave as a FIFO of at most two packets.
    int              n_acc;
    int              n_drn;
    logic [AW-1:0]   lens_m [2];
    logic [DW-1:0]   mem_m [int];
    logic            exp_rd_known;
    logic [DW-1:0]   exp_rd;

    initial begin
        // columns: we wa wd wdn wl re ra fd | rfw rff len chk_rd rd
        vecs[0]  = mk(0, 0, 64'h0,    0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h0);
        vecs[1]  = mk(1, 0, 64'hA0,   0, 0, 0, 0, 0, 1, 0, 0, 0, 64'h0);
        vecs[2]  = mk(1, 1, 64'hA1,   0, 0, 0, 0, 0, 1, 0, 0, 0, 64'h0);
        vecs[3]  = mk(1, 2, 64'hA2,   0, 0, 0, 0, 0, 1, 0, 0, 0, 64'h0);
        vecs[4]  = mk(1, 3, 64'hA3,   0, 0, 0, 0, 0, 1, 0, 0, 0, 64'h0);
        vecs[5]  = mk(0, 0, 64'h0,    1, 4, 0, 0, 0, 1, 1, 4, 0, 64'h0);
        vecs[6]  = mk(0, 0, 64'h0,    0, 0, 1, 2, 0, 1, 1, 4, 1, 64'hA2);
        vecs[7]  = mk(0, 0, 64'h0,    0, 0, 1, 0, 0, 1, 1, 4, 1, 64'hA0);
        vecs[8]  = mk(0, 0, 64'h0,    0, 0, 0, 0, 1, 1, 0, 0, 1, 64'hA0);
        vecs[9]  = mk(1, 0, 64'hB0,   0, 0, 0, 0, 0, 1, 0, 0, 0, 64'h0);
        vecs[10] = mk(0, 0, 64'h0,    1, 0, 0, 0, 0, 1, 0, 0, 0, 64'h0);
        vecs[11] = mk(0, 0, 64'h0,    1, 3, 0, 0, 0, 1, 1, 3, 0, 64'h0);
        vecs[12] = mk(0, 0, 64'h0,    1, 5, 0, 0, 0, 0, 1, 3, 0, 64'h0);
        vecs[13] = mk(1, 0, 64'hDEAD, 1, 2, 0, 0, 0, 0, 1, 3, 0, 64'h0);
        vecs[14] = mk(0, 0, 64'h0,    0, 0, 1, 0, 0, 0, 1, 3, 1, 64'hB0);
        vecs[15] = mk(0, 0, 64'h0,    0, 0, 0, 0, 1, 1, 1, 5, 0, 64'h0);
        vecs[16] = mk(0, 0, 64'h0,    1, 7, 0, 0, 1, 1, 1, 7, 0, 64'h0);
        vecs[17] = mk(0, 0, 64'h0,    1, 2, 0, 0, 0, 0, 1, 7, 0, 64'h0);
        vecs[18] = mk(0, 0, 64'h0,    0, 0, 1, 0, 0, 0, 1, 7, 1, 64'hB0);

        axi_aresetn = 1'b0;
        idle();
        @(negedge axi_aclk);
        check("reset_rfw", 64'(ready_for_writer), 64'd1);
        check("reset_rff", 64'(ready_for_forwarder), 64'd0);
        check("reset_len", 64'(len_to_forwarder), 64'd0);
        check("reset_rd", forwarder_rd_data, 64'd0);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;

        @(negedge axi_aclk);
        apply(vecs[0]);
        for (int i = 0; i < NV; i++) begin
            @(negedge axi_aclk);
            check($sformatf("vec%0d_rfw", i), 64'(ready_for_writer), 64'(vecs[i].e_rfw));
            check($sformatf("vec%0d_rff", i), 64'(ready_for_forwarder), 64'(vecs[i].e_rff));
            check($sformatf("vec%0d_len", i), 64'(len_to_forwarder), 64'(vecs[i].e_len));
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_rd", i), forwarder_rd_data, vecs[i].e_rd);
            end
            if (i + 1 < NV) apply(vecs[i + 1]);
            else idle();
        end

        // Both slots FULL with non-zero read data; reset must clear asynchronously.
        #1 axi_aresetn = 1'b0;
        #1;
        check("midreset_rfw", 64'(ready_for_writer), 64'd1);
        check("midreset_rff", 64'(ready_for_forwarder), 64'd0);
        check("midreset_len", 64'(len_to_forwarder), 64'd0);
        check("midreset_rd", forwarder_rd_data, 64'd0);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        drive(1'b1, 10'd0, 64'hC0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge axi_aclk);
        drive(1'b0, '0, '0, 1'b1, 10'd1, 1'b0, '0, 1'b0);
        @(negedge axi_aclk);
        check("post_reset_rff", 64'(ready_for_forwarder), 64'd1);
        check("post_reset_len", 64'(len_to_forwarder), 64'd1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 10'd0, 1'b0);
        @(negedge axi_aclk);
        check("post_reset_rd", forwarder_rd_data, 64'hC0);
        idle();

        // Randomized phase against the FIFO-of-packets model.
        axi_aresetn = 1'b0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        n_acc = 0;
        n_drn = 0;
        lens_m[0] = '0;
        lens_m[1] = '0;
        mem_m.delete();
        exp_rd_known = 1'b1;
        exp_rd = '0;
        for (int c = 0; c < 3000; c++) begin
            logic          r_we, r_wdn, r_re, r_fd;
            logic [AW-1:0] r_wa, r_wl, r_ra;
            logic [DW-1:0] r_wd;
            logic          rdy_w, rdy_f;
            int            wps, rps;

            check("rnd_rfw", 64'(ready_for_writer), 64'((n_acc - n_drn) < 2));
            check("rnd_rff", 64'(ready_for_forwarder), 64'((n_acc - n_drn) > 0));
            check("rnd_len", 64'(len_to_forwarder), 64'(lens_m[n_drn % 2]));
            if (exp_rd_known) check("rnd_rd", forwarder_rd_data, exp_rd);

            r_we  = ($urandom_range(1) == 0);
            r_wa  = AW'($urandom_range(7));
            r_wd  = {$urandom, $urandom};
            r_wdn = ($urandom_range(5) == 0);
            r_wl  = ($urandom_range(3) == 0) ? '0 : AW'($urandom_range(1, 8));
            r_re  = ($urandom_range(1) == 0);
            r_ra  = AW'($urandom_range(7));
            r_fd  = ($urandom_range(4) == 0);
            drive(r_we, r_wa, r_wd, r_wdn, r_wl, r_re, r_ra, r_fd);

            @(posedge axi_aclk);
            rdy_w = (n_acc - n_drn) < 2;
            rdy_f = (n_acc - n_drn) > 0;
            wps = n_acc % 2;
            rps = n_drn % 2;
            if (r_re) begin
                if (rdy_f && mem_m.exists(rps * 1024 + int'(r_ra))) begin
                    exp_rd_known = 1'b1;
                    exp_rd = mem_m[rps * 1024 + int'(r_ra)];
                end else begin
                    exp_rd_known = 1'b0;
                end
            end
            if (r_we && rdy_w) mem_m[wps * 1024 + int'(r_wa)] = r_wd;
            if (r_wdn && rdy_w && (r_wl != '0)) begin
                lens_m[wps] = r_wl;
                n_acc++;
            end
            if (r_fd && rdy_f) n_drn++;
            @(negedge axi_aclk);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
